// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the registered ALU (alu_icc_seq) and its iterative
//   multiplier (alu_mul_iter).
//   Contents: opcode field positions, function-code enums for both opcode
//   groups, bit indices into the {N,Z,C,V} condition-code register, and the
//   multiply FSM state enum.
//   Configuration macro: ALU_MUL_EN (consumed by alu_icc_seq, not here).
// ---------------------------------------------------------------------------
package alu_pkg;

  // Opcode layout: [5] group, [4] S (update icc), [3] X (carry-in from icc.C),
  // [2:0] function.
  localparam int OP_GROUP = 5;
  localparam int OP_S     = 4;
  localparam int OP_X     = 3;

  typedef enum logic [2:0] {
    F0_ADD  = 3'b000,
    F0_AND  = 3'b001,
    F0_OR   = 3'b010,
    F0_XOR  = 3'b011,
    F0_SUB  = 3'b100,
    F0_NAND = 3'b101,
    F0_NOR  = 3'b110,
    F0_XNOR = 3'b111
  } func0_e;

  typedef enum logic [2:0] {
    F1_UMUL = 3'b000,
    F1_SMUL = 3'b001,
    F1_RSV2 = 3'b010,
    F1_RSV3 = 3'b011,
    F1_RSV4 = 3'b100,
    F1_SLL  = 3'b101,
    F1_SRL  = 3'b110,
    F1_SRA  = 3'b111
  } func1_e;

  // icc = {N,Z,C,V}
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_C = 1;
  localparam int ICC_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
//   Radix-2 shift-add multiplier, one multiplier bit per cycle, WIDTH cycles.
//   Signed operation multiplies magnitudes and negates the product when the
//   operand signs differ.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     start           load operands; first step happens on the next edge
//     signed_op       1 = signed (SMUL), 0 = unsigned (UMUL)
//     a, b            operands, sampled when start is high
//     done            high during the cycle whose closing edge is the last
//                     step; prod_lo/prod_hi are valid during that cycle
//     prod_lo/prod_hi final product (combinational, qualified by done)
//   Only instantiated when ALU_MUL_EN is defined.
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier, shifted out as product fills in
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             run_q, run_d;

  logic [WIDTH:0]     add;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    add     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    step_hi = add[WIDTH:1];
    step_lo = {add[0], lo_q[WIDTH-1:1]};
    done    = run_q && (cnt_q == CW'(WIDTH - 1));
    prod    = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    prod_lo = prod[WIDTH-1:0];
    prod_hi = prod[2*WIDTH-1:WIDTH];

    mcand_d = mcand_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    run_d   = run_q;

    if (start) begin
      mcand_d = (signed_op && a[WIDTH-1]) ? -a : a;
      lo_d    = (signed_op && b[WIDTH-1]) ? -b : b;
      hi_d    = '0;
      cnt_d   = '0;
      neg_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      run_d   = 1'b1;
    end else if (run_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/alu_icc_seq.sv
// ---------------------------------------------------------------------------
// alu_icc_seq
//   Registered ALU with an internal {N,Z,C,V} condition-code register and a
//   valid/ready input handshake. Single-cycle ops register their result at
//   the accept edge; UMUL/SMUL run on an iterative multiplier for WIDTH
//   cycles and complete WIDTH+1 cycles after accept.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   operation handshake (accept = in_valid && in_ready)
//     opcode              [5] group, [4] S, [3] X, [2:0] func
//     a, b                operands; shift amount is b[SHW-1:0]
//     out_valid           one-cycle pulse when result is updated
//     result/result_hi    low result / high half of a product (else 0)
//     icc                 {N,Z,C,V}
//     illegal             pulses with out_valid for a reserved opcode
//   Configuration: define ALU_MUL_EN to build UMUL/SMUL and the multiply FSM.
//   Without it those opcodes are reserved, in_ready is tied 1 and result_hi
//   is tied 0.
// ---------------------------------------------------------------------------
module alu_icc_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ICC_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       icc,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic             grp, s_bit, cin, accept;
  logic [2:0]       func;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_illegal, is_mul;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_d;
  logic [3:0]       icc_q, icc_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;

  assign grp    = opcode[OP_GROUP];
  assign s_bit  = opcode[OP_S];
  assign func   = opcode[2:0];
  assign sh     = b[SHW-1:0];
  assign cin    = opcode[OP_X] & icc_q[ICC_C];
  assign accept = in_valid && in_ready;

  // Single-cycle datapath. Borrow is the top bit of the (WIDTH+1)-bit
  // difference, i.e. set when a < b + cin unsigned.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    sc_res     = '0;
    sc_c       = 1'b0;
    sc_v       = 1'b0;
    sc_illegal = 1'b0;
    is_mul     = 1'b0;
    if (!grp) begin
      unique case (func0_e'(func))
        F0_ADD: begin
          sc_res = sum[WIDTH-1:0];
          sc_c   = sum[WIDTH];
          sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        F0_SUB: begin
          sc_res = diff[WIDTH-1:0];
          sc_c   = diff[WIDTH];
          sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        F0_AND:  sc_res = a & b;
        F0_OR:   sc_res = a | b;
        F0_XOR:  sc_res = a ^ b;
        F0_NAND: sc_res = ~(a & b);
        F0_NOR:  sc_res = ~(a | b);
        F0_XNOR: sc_res = ~(a ^ b);
        default: sc_res = '0;
      endcase
    end else begin
      unique case (func1_e'(func))
        F1_SLL:  sc_res = a << sh;
        F1_SRL:  sc_res = a >> sh;
        F1_SRA:  sc_res = $signed(a) >>> sh;
`ifdef ALU_MUL_EN
        F1_UMUL, F1_SMUL: is_mul = 1'b1;
`endif
        default: sc_illegal = 1'b1;
      endcase
    end
  end

`ifdef ALU_MUL_EN
  state_e           state_q, state_d;
  logic             mul_s_q, mul_s_d;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi;
  logic [WIDTH-1:0] result_hi_q;

  assign mul_start = accept && is_mul;
  assign in_ready  = (state_q == IDLE);
  assign result_hi = result_hi_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .signed_op (func[0]),
    .a         (a),
    .b         (b),
    .done      (mul_done),
    .prod_lo   (mul_lo),
    .prod_hi   (mul_hi)
  );
`else
  assign in_ready  = 1'b1;
  assign result_hi = '0;
`endif

  always_comb begin
    result_d    = result_q;
    result_hi_d = '0;
    icc_d       = icc_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
`ifdef ALU_MUL_EN
    result_hi_d = result_hi_q;
    state_d     = state_q;
    mul_s_d     = mul_s_q;
`endif
    if (accept && !is_mul) begin
      result_d    = sc_illegal ? '0 : sc_res;
      result_hi_d = '0;
      out_valid_d = 1'b1;
      illegal_d   = sc_illegal;
      if (s_bit && !sc_illegal)
        icc_d = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
    end
`ifdef ALU_MUL_EN
    if (mul_start) begin
      state_d = BUSY;
      mul_s_d = s_bit;   // flags are written with the product, not at accept
    end
    if (state_q == BUSY && mul_done) begin
      state_d     = IDLE;
      result_d    = mul_lo;
      result_hi_d = mul_hi;
      out_valid_d = 1'b1;
      if (mul_s_q) icc_d = {mul_lo[WIDTH-1], (mul_lo == '0), 1'b0, 1'b0};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      icc_q       <= ICC_RST;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      icc_q       <= icc_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mul_s_q     <= 1'b0;
      result_hi_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_s_q     <= mul_s_d;
      result_hi_q <= result_hi_d;
    end
  end
`endif

  assign result    = result_q;
  assign icc       = icc_q;
  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_icc_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_icc_seq
//   Self-checking bench for alu_icc_seq (WIDTH=32). Expected values come from
//   a behavioural model using 64-bit arithmetic and a model icc register.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Multiply tests are built when ALU_MUL_EN is defined; otherwise the bench
//   checks that UMUL/SMUL are reported as reserved.
// ---------------------------------------------------------------------------
module tb_alu_icc_seq;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic [W-1:0]  result, result_hi;
  logic [3:0]    icc;
  logic          illegal;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [3:0]    m_icc;       // model condition codes

  always #5 clk = ~clk;

  alu_icc_seq #(.WIDTH(W), .ICC_RST(4'b0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .icc       (icc),
    .illegal   (illegal)
  );

  // Behavioural reference: computes an operation's outcome from the opcode
  // rules with wide integer arithmetic and advances m_icc when S is set.
  function automatic void model(input logic [5:0] op, input logic [31:0] av, bv,
                                output logic [31:0] r, output logic [31:0] rh,
                                output logic ill);
    logic [63:0] wide;
    longint      sa, sb, sv;
    logic        cin, c, v;
    cin = op[3] ? m_icc[1] : 1'b0;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    c = 1'b0; v = 1'b0; ill = 1'b0; rh = '0; r = '0;
    if (!op[5]) begin
      case (op[2:0])
        3'd0: begin
          wide = {32'b0, av} + {32'b0, bv} + 64'(cin);
          r = wide[31:0]; c = wide[32];
          sv = sa + sb + longint'(cin);
          v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        end
        3'd4: begin
          r = av - bv - 32'(cin);
          c = ({32'b0, av} < ({32'b0, bv} + 64'(cin)));
          sv = sa - sb - longint'(cin);
          v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        end
        3'd1: r = av & bv;
        3'd2: r = av | bv;
        3'd3: r = av ^ bv;
        3'd5: r = ~(av & bv);
        3'd6: r = ~(av | bv);
        default: r = ~(av ^ bv);
      endcase
    end else begin
      case (op[2:0])
        3'd5: r = av << bv[4:0];
        3'd6: r = av >> bv[4:0];
        3'd7: begin
          wide = 64'(sa) >> bv[4:0];   // sign-extended to 64 bits first
          r = wide[31:0];
        end
        3'd0, 3'd1: begin
          if (!MUL_EN) ill = 1'b1;
          else begin
            if (op[0]) wide = 64'(sa * sb);
            else       wide = {32'b0, av} * {32'b0, bv};
            r = wide[31:0]; rh = wide[63:32];
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      r = '0; rh = '0;
    end else if (op[4]) begin
      m_icc = {r[31], (r == 32'b0), c, v};
    end
  endfunction

  // Drives one operation from a falling edge, lets it be accepted on the next
  // rising edge and returns at the following falling edge with the model's
  // expectation. in_valid is left high so calls chain back-to-back.
  task automatic do_op(input logic [5:0] op, input logic [31:0] av, bv,
                       output logic [31:0] er, output logic [31:0] erh,
                       output logic ei);
    in_valid = 1'b1; opcode = op; a = av; b = bv;
    model(op, av, bv, er, erh, ei);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [4];
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h8000_0000; edges[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
    m_icc = 4'b0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, illegal} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,illegal} got %b expected 100",
               {in_ready, out_valid, illegal});
    end
    n_checks++;
    if ({result, result_hi} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: result %h result_hi %h expected 0", result, result_hi);
    end
    n_checks++;
    if (icc !== 4'b0000) begin
      n_fail++; $display("FAIL reset_icc: got %b expected 0000", icc);
    end
    rst = 1'b0;
  endtask

  // Back-to-back sequence from the test plan, with the required values
  // written out as constants.
  task automatic test_directed();
    logic [5:0]  ops  [5] = '{6'b010000, 6'b001000, 6'b010100, 6'b100111, 6'b100010};
    logic [31:0] as   [5] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'h80000000, 32'h12345678};
    logic [31:0] bs   [5] = '{32'h1, 32'h1, 32'h2, 32'h4, 32'h9};
    logic [31:0] xr   [5] = '{32'h0, 32'h3, 32'hFFFFFFFF, 32'hF8000000, 32'h0};
    logic [3:0]  xicc [5] = '{4'b0110, 4'b0110, 4'b1010, 4'b1010, 4'b1010};
    logic        xill [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] er, erh;
    logic        ei;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], er, erh, ei);
      n_checks++;
      if (result !== xr[i] || result_hi !== 32'h0) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h_%h expected 00000000_%h",
                 i, result_hi, result, xr[i]);
      end
      n_checks++;
      if (icc !== xicc[i]) begin
        n_fail++; $display("FAIL directed_icc[%0d]: got %b expected %b", i, icc, xicc[i]);
      end
      n_checks++;
      if (out_valid !== 1'b1 || illegal !== xill[i]) begin
        n_fail++;
        $display("FAIL directed_flags[%0d]: out_valid %b illegal %b expected 1 %b",
                 i, out_valid, illegal, xill[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  // out_valid is a single-cycle pulse and result holds afterwards.
  task automatic test_pulse_hold();
    logic [31:0] er, erh;
    logic        ei;
    do_op(6'b000011, 32'hF0F0F0F0, 32'h0F0F0F0F, er, erh, ei);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || illegal !== 1'b0 || result !== 32'hFFFFFFFF) begin
        n_fail++;
        $display("FAIL pulse_hold[%0d]: out_valid %b illegal %b result %h expected 0 0 ffffffff",
                 i, out_valid, illegal, result);
      end
    end
  endtask

  // Random single-cycle ops, mostly back-to-back with occasional idle cycles.
  task automatic test_random_single();
    logic [31:0] er, erh, last_r;
    logic        ei;
    logic [5:0]  op;
    last_r = result;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || result !== last_r) begin
          n_fail++;
          $display("FAIL rand_idle[%0d]: out_valid %b result %h expected 0 %h",
                   i, out_valid, result, last_r);
        end
      end else begin
        op = 6'($urandom);
        if (op[5] && op[2:1] == 2'b00 && MUL_EN) op[2:0] = 3'b101;
        do_op(op, pick_operand(), ($urandom_range(0, 3) == 0) ? 32'h0 : pick_operand(),
              er, erh, ei);
        last_r = er;
        n_checks++;
        if (out_valid !== 1'b1 || illegal !== ei || result !== er || result_hi !== erh
            || icc !== m_icc || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_op[%0d] op %b a %h b %h: got v%b i%b %h_%h icc %b rdy %b expected v1 i%b %h_%h icc %b rdy 1",
                   i, op, a, b, out_valid, illegal, result_hi, result, icc, in_ready,
                   ei, erh, er, m_icc);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef ALU_MUL_EN
  // One multiply: in_ready low for W cycles, result in cycle W+1 after accept.
  task automatic run_mul(input logic [5:0] op, input logic [31:0] av, bv);
    logic [31:0] er, erh;
    logic        ei;
    do_op(op, av, bv, er, erh, ei);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc <= W) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mul_busy cycle %0d: in_ready %b out_valid %b expected 0 0",
                   cyc, in_ready, out_valid);
        end
      end else begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL mul_done: out_valid %b in_ready %b illegal %b expected 1 1 0",
                   out_valid, in_ready, illegal);
        end
        n_checks++;
        if (result !== er || result_hi !== erh || icc !== m_icc) begin
          n_fail++;
          $display("FAIL mul_value op %b a %h b %h: got %h_%h icc %b expected %h_%h icc %b",
                   op, av, bv, result_hi, result, icc, erh, er, m_icc);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mul_pulse: out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_mul();
    run_mul(6'b110000, 32'hFFFFFFFF, 32'h2);
    n_checks++;
    if ({result_hi, result} !== 64'h00000001_FFFFFFFE || icc !== 4'b1000) begin
      n_fail++;
      $display("FAIL umul_plan: got %h_%h icc %b expected 00000001_fffffffe icc 1000",
               result_hi, result, icc);
    end
    run_mul(6'b100001, 32'hFFFFFFFD, 32'h5);
    n_checks++;
    if ({result_hi, result} !== 64'hFFFFFFFF_FFFFFFF1) begin
      n_fail++;
      $display("FAIL smul_plan: got %h_%h expected ffffffff_fffffff1", result_hi, result);
    end
    for (int i = 0; i < 6; i++)
      run_mul({1'b1, 1'($urandom), 3'b000, 1'($urandom)}, pick_operand(), pick_operand());
  endtask
`else
  task automatic test_mul();
    logic [31:0] er, erh;
    logic        ei;
    for (int i = 0; i < 2; i++) begin
      do_op({1'b1, 1'b1, 3'b000, 1'(i)}, 32'h7, 32'h9, er, erh, ei);
      n_checks++;
      if (illegal !== 1'b1 || out_valid !== 1'b1 || result !== 32'h0 || result_hi !== 32'h0
          || icc !== m_icc || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_disabled[%0d]: illegal %b out_valid %b result %h_%h icc %b rdy %b expected 1 1 0_0 icc %b rdy 1",
                 i, illegal, out_valid, result_hi, result, icc, in_ready, m_icc);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  // Reset mid-operation: outputs return to reset values at once and the
  // aborted operation never produces out_valid.
  task automatic test_reset_abort();
    logic [31:0] er, erh;
    logic        ei;
    logic        seen;
    do_op(6'b010100, 32'h1, 32'h2, er, erh, ei);    // leaves icc = 1010
    do_op(6'b110000, 32'hFFFFFFFF, 32'h2, er, erh, ei);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    m_icc = 4'b0000;
    n_checks++;
    if (in_ready !== 1'b1 || icc !== 4'b0000 || out_valid !== 1'b0 || result !== 32'h0
        || result_hi !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset: in_ready %b icc %b out_valid %b result %h_%h expected 1 0000 0 0_0",
               in_ready, icc, out_valid, result_hi, result);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || icc !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_no_valid: out_valid seen %b icc %b expected 0 0000", seen, icc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_pulse_hold();
    test_random_single();
    test_mul();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
